parking_gate_controller: RTL and testbench
==========================================

Name: parking_gate_controller

Overview:
- Sequential controller that owns the lot occupancy count and drives the entry and exit barrier gates from the car sensors.
- Each committed passage produces a +1 (entry) or -1 (exit) occupancy update, which the controller computes internally with a 3-bit signed-step adder.
- Occupancy, full and empty status feed the display and sign logic of the smart parking system.

Parameters:
- CAPACITY, 7, number of spaces; legal range 1..7, fits the 3-bit count.
- GATE_TICKS, 8, cycles a gate stays open waiting for a pass before auto-close; legal range 1..255. Used only when GATE_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- entry_req  input  1  car present at entry; level, synchronous to clk.
- entry_pass  input  1  entry pass sensor; 1-cycle pulse when the car clears the barrier.
- exit_req  input  1  car present at exit; level.
- exit_pass  input  1  exit pass sensor; 1-cycle pulse.
- entry_gate  output  1  1 = entry barrier open.
- exit_gate  output  1  1 = exit barrier open.
- occupancy  output  3  cars currently inside, 0..CAPACITY.
- full  output  1  occupancy == CAPACITY.
- empty  output  1  occupancy == 0.
- entry_deny  output  1  1-cycle pulse: entry_req rejected because the lot is full.
- exit_deny  output  1  1-cycle pulse: exit_req rejected because the lot is empty.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - occupancy=0, empty=1, full=0.
  - Both gates 0, both deny outputs 0, both gate FSMs in IDLE, timers cleared.
  - Reset mid-operation drops the open gate and discards the passage in progress.
- Per-gate FSM, one instance per gate, states IDLE, OPEN, HOLD:
  - IDLE -> OPEN when req=1 and allow=1. Entry allow = !full; exit allow = !empty. The gate output is registered and goes high the cycle after req is sampled (1-cycle latency).
  - IDLE with req=1 and allow=0: stay in IDLE and pulse deny for 1 cycle. The pulse repeats every 2 cycles while req stays high (IDLE -> IDLE via one cooldown cycle).
  - OPEN -> HOLD on pass=1. The gate drops the next cycle. The commit pulse to the counter is issued on the same edge.
  - HOLD -> IDLE when req=0. This prevents the same car re-triggering the gate.
  - pass=1 in IDLE or HOLD is ignored: no count change and no gate change.
- Occupancy update, registered on the commit edge:
  - Entry commit only: +1. Exit commit only: -1. Both in the same cycle: unchanged.
  - The update is computed as occupancy + (step XOR sub) + sub on 3 bits, with the carry discarded.
  - The count never wraps. Entry opens only when count < CAPACITY and exit only when count > 0, so the result stays within 0..CAPACITY.
- full and empty are combinational decodes of registered occupancy; they reflect the new count the cycle after a commit.
- Entry allow is evaluated at the IDLE->OPEN decision only. An exit commit while the entry gate is open is legal.
- Simultaneous entry_req and exit_req: the two gates are independent and both may open in the same cycle.

Optional Feature:
- Macro: GATE_TIMEOUT_EN.
- When defined:
  - OPEN holds an 8-bit down-counter loaded with GATE_TICKS on entry to OPEN.
  - On reaching 0 without a pass, the FSM goes OPEN -> HOLD and the gate closes with no count change.
  - A pass in the same cycle as the timeout wins and commits normally.
- When undefined: OPEN waits indefinitely for pass; no timer logic is present.

Decomposition:
- Package parking_pkg holds:
  - gate_state_t enum (IDLE, OPEN, HOLD);
  - constant OCC_W=3;
  - constant TIMER_W=8.
- Sub-module gate_fsm is instantiated twice (entry and exit).
  - Inputs: clk, rst, req, pass, allow.
  - Outputs: gate, commit, deny.
- The top level holds the occupancy register, the add/subtract step and the full/empty decode.

Test Plan:
- Reset with occupancy nonzero -> occupancy=0, empty=1, gates 0, asynchronously, before the next clk edge.
- entry_req=1 at cycle 0 -> entry_gate=1 at cycle 1; entry_pass pulse at cycle 3 -> entry_gate=0 and occupancy=1 at cycle 4.
- Fill to CAPACITY=7 -> full=1; a further entry_req -> entry_gate stays 0 and entry_deny pulses every 2 cycles.
- Occupancy=3, entry and exit both open, both pass pulses in the same cycle -> occupancy stays 3 and both gates close.
- empty=1, exit_req=1 -> exit_deny pulse and exit_gate stays 0; a stray exit_pass while IDLE -> no change.
- GATE_TIMEOUT_EN with GATE_TICKS=8: entry opened and no pass given -> gate closes after 8 cycles, occupancy unchanged; gate does not reopen until entry_req falls and rises again.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and widths for the parking gate controller.
package parking_pkg;

   localparam int unsigned OCC_W   = 3;
   localparam int unsigned TIMER_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      HOLD = 2'd2
   } gate_state_t;

endpackage

// File: rtl/gate_fsm.sv
// One barrier gate: IDLE/OPEN/HOLD sequencing, deny pulses and commit strobe.
// Optional macro GATE_TIMEOUT_EN adds an auto-close down-counter in OPEN.
module gate_fsm
   import parking_pkg::*;
#(
   parameter int unsigned GATE_TICKS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic pass,
   input  logic allow,
   output logic gate,
   output logic commit,
   output logic deny
);

   gate_state_t state_q, state_d;
   logic        deny_q, deny_d;

`ifdef GATE_TIMEOUT_EN
   localparam logic [TIMER_W-1:0] TICKS = TIMER_W'(GATE_TICKS);
   logic [TIMER_W-1:0] timer_q, timer_d;

   // Timer register, only meaningful while OPEN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`endif

   // State and deny registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         deny_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         deny_q  <= deny_d;
      end
   end

   // Next-state, deny cooldown and commit strobe.
   always_comb begin
      state_d = state_q;
      deny_d  = 1'b0;
      commit  = 1'b0;
`ifdef GATE_TIMEOUT_EN
      timer_d = timer_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               if (allow) begin
                  state_d = OPEN;
`ifdef GATE_TIMEOUT_EN
                  timer_d = TICKS;
`endif
               end else begin
                  // Alternate pulse/cooldown while the request is held.
                  deny_d = !deny_q;
               end
            end
         end
         OPEN: begin
            // A pass wins over a simultaneous timeout.
            if (pass) begin
               commit  = 1'b1;
               state_d = HOLD;
            end
`ifdef GATE_TIMEOUT_EN
            else if (timer_q <= TIMER_W'(1)) begin
               state_d = HOLD;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
`endif
         end
         HOLD: begin
            // Wait for the car to leave the request sensor before re-arming.
            if (!req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gate = (state_q == OPEN);
   assign deny = deny_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking lot controller: occupancy counter plus entry and exit gate FSMs.
// Optional macro GATE_TIMEOUT_EN enables gate auto-close after GATE_TICKS cycles.
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY   = 7,
   parameter int unsigned GATE_TICKS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_req,
   input  logic             entry_pass,
   input  logic             exit_req,
   input  logic             exit_pass,
   output logic             entry_gate,
   output logic             exit_gate,
   output logic [OCC_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             entry_deny,
   output logic             exit_deny
);

   localparam logic [OCC_W-1:0] CAP  = OCC_W'(CAPACITY);
   localparam logic [OCC_W-1:0] STEP = OCC_W'(1);

   logic [OCC_W-1:0] occ_q, occ_d;
   logic             entry_commit, exit_commit;
   logic             sub;

   gate_fsm #(
      .GATE_TICKS (GATE_TICKS)
   ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .req    (entry_req),
      .pass   (entry_pass),
      .allow  (!full),
      .gate   (entry_gate),
      .commit (entry_commit),
      .deny   (entry_deny)
   );

   gate_fsm #(
      .GATE_TICKS (GATE_TICKS)
   ) u_exit (
      .clk    (clk),
      .rst    (rst),
      .req    (exit_req),
      .pass   (exit_pass),
      .allow  (!empty),
      .gate   (exit_gate),
      .commit (exit_commit),
      .deny   (exit_deny)
   );

   // Signed-step adder: +1 on entry, -1 (two's complement) on exit, hold if both or neither.
   always_comb begin
      sub   = exit_commit;
      occ_d = occ_q;
      if (entry_commit ^ exit_commit) begin
         occ_d = occ_q + (STEP ^ {OCC_W{sub}}) + OCC_W'(sub);
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;
   assign full      = (occ_q == CAP);
   assign empty     = (occ_q == '0);

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed self-checking bench for parking_gate_controller (CAPACITY=7, GATE_TICKS=8).
module tb_parking_gate_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       entry_req = 1'b0;
   logic       entry_pass = 1'b0;
   logic       exit_req = 1'b0;
   logic       exit_pass = 1'b0;
   logic       entry_gate, exit_gate, full, empty, entry_deny, exit_deny;
   logic [2:0] occupancy;

   int total = 0;
   int bad   = 0;

   parking_gate_controller dut (
      .clk        (clk),
      .rst        (rst),
      .entry_req  (entry_req),
      .entry_pass (entry_pass),
      .exit_req   (exit_req),
      .exit_pass  (exit_pass),
      .entry_gate (entry_gate),
      .exit_gate  (exit_gate),
      .occupancy  (occupancy),
      .full       (full),
      .empty      (empty),
      .entry_deny (entry_deny),
      .exit_deny  (exit_deny)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_entry();
      entry_req = 1'b1;
      tick();
      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      entry_req  = 1'b0;
      tick();
   endtask

   task automatic do_exit();
      exit_req = 1'b1;
      tick();
      exit_pass = 1'b1;
      tick();
      exit_pass = 1'b0;
      exit_req  = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_occ", 8'(occupancy), 8'd0);
      chk("rst_empty", 8'(empty), 8'd1);
      chk("rst_full", 8'(full), 8'd0);
      chk("rst_egate", 8'(entry_gate), 8'd0);
      chk("rst_xgate", 8'(exit_gate), 8'd0);
      chk("rst_edeny", 8'(entry_deny), 8'd0);
      tick();
      rst = 1'b0;
      tick();

      // Basic entry: gate opens one cycle after req, closes after pass
      entry_req = 1'b1;
      tick();
      chk("ent_gate_c1", 8'(entry_gate), 8'd1);
      tick();
      tick();
      chk("ent_gate_c3", 8'(entry_gate), 8'd1);
      chk("ent_occ_c3", 8'(occupancy), 8'd0);
      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      chk("ent_gate_c4", 8'(entry_gate), 8'd0);
      chk("ent_occ_c4", 8'(occupancy), 8'd1);
      chk("ent_empty_c4", 8'(empty), 8'd0);
      // Req still high in HOLD: no re-trigger
      tick();
      tick();
      chk("hold_no_reopen", 8'(entry_gate), 8'd0);
      entry_req = 1'b0;
      tick();

      // Stray exit_pass while exit gate idle
      exit_pass = 1'b1;
      tick();
      exit_pass = 1'b0;
      chk("stray_xpass_occ", 8'(occupancy), 8'd1);
      chk("stray_xpass_gate", 8'(exit_gate), 8'd0);
      // Stray entry_pass while entry gate idle
      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      chk("stray_epass_occ", 8'(occupancy), 8'd1);

      // Fill to capacity
      for (int i = 0; i < 6; i++) do_entry();
      chk("fill_occ", 8'(occupancy), 8'd7);
      chk("fill_full", 8'(full), 8'd1);

      // Entry denied while full: pulse every two cycles
      entry_req = 1'b1;
      tick();
      chk("deny_c1", 8'(entry_deny), 8'd1);
      chk("deny_gate_c1", 8'(entry_gate), 8'd0);
      tick();
      chk("deny_c2", 8'(entry_deny), 8'd0);
      tick();
      chk("deny_c3", 8'(entry_deny), 8'd1);
      chk("deny_gate_c3", 8'(entry_gate), 8'd0);
      entry_req = 1'b0;
      tick();
      tick();
      chk("deny_occ", 8'(occupancy), 8'd7);

      // Down to 3
      for (int i = 0; i < 4; i++) do_exit();
      chk("down_occ", 8'(occupancy), 8'd3);
      chk("down_full", 8'(full), 8'd0);

      // Both gates open together, both pass together
      entry_req = 1'b1;
      exit_req  = 1'b1;
      tick();
      chk("both_egate", 8'(entry_gate), 8'd1);
      chk("both_xgate", 8'(exit_gate), 8'd1);
      entry_pass = 1'b1;
      exit_pass  = 1'b1;
      tick();
      entry_pass = 1'b0;
      exit_pass  = 1'b0;
      chk("both_occ", 8'(occupancy), 8'd3);
      chk("both_egate_closed", 8'(entry_gate), 8'd0);
      chk("both_xgate_closed", 8'(exit_gate), 8'd0);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      tick();

      // Exit commit while entry gate is open
      entry_req = 1'b1;
      tick();
      exit_req = 1'b1;
      tick();
      exit_pass = 1'b1;
      tick();
      exit_pass = 1'b0;
      exit_req  = 1'b0;
      chk("mix_occ_after_exit", 8'(occupancy), 8'd2);
      chk("mix_egate_open", 8'(entry_gate), 8'd1);
      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      entry_req  = 1'b0;
      chk("mix_occ_after_entry", 8'(occupancy), 8'd3);
      tick();

      // Drain to empty, then exit is denied
      for (int i = 0; i < 3; i++) do_exit();
      chk("drain_occ", 8'(occupancy), 8'd0);
      chk("drain_empty", 8'(empty), 8'd1);
      exit_req = 1'b1;
      tick();
      chk("xdeny_c1", 8'(exit_deny), 8'd1);
      chk("xdeny_gate", 8'(exit_gate), 8'd0);
      tick();
      chk("xdeny_c2", 8'(exit_deny), 8'd0);
      exit_req = 1'b0;
      tick();

      // Gate with no pass: auto-close if enabled, otherwise stays open
      entry_req = 1'b1;
      tick();
      chk("to_open", 8'(entry_gate), 8'd1);
`ifdef GATE_TIMEOUT_EN
      repeat (7) tick();
      chk("to_still_open_c8", 8'(entry_gate), 8'd1);
      tick();
      chk("to_closed_c9", 8'(entry_gate), 8'd0);
      chk("to_occ", 8'(occupancy), 8'd0);
      tick();
      tick();
      chk("to_no_reopen", 8'(entry_gate), 8'd0);
      entry_req = 1'b0;
      tick();
      entry_req = 1'b1;
      tick();
      chk("to_reopen", 8'(entry_gate), 8'd1);
`else
      repeat (20) tick();
      chk("nto_still_open", 8'(entry_gate), 8'd1);
`endif
      entry_pass = 1'b1;
      tick();
      entry_pass = 1'b0;
      entry_req  = 1'b0;
      chk("late_pass_occ", 8'(occupancy), 8'd1);
      tick();

      // Asynchronous reset mid-passage
      entry_req = 1'b1;
      tick();
      chk("ar_open", 8'(entry_gate), 8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_occ", 8'(occupancy), 8'd0);
      chk("ar_empty", 8'(empty), 8'd1);
      chk("ar_gate", 8'(entry_gate), 8'd0);
      entry_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("ar_after_occ", 8'(occupancy), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
